// File: rtl/exp_term_decomp.sv
// Decomposes an unsigned Q IW.11 operand into ln-table terms (ln2, ln(1+2^-i)), emitting one multiplier per term.
// Optional macro EXP_TERM_DECOMP_RESID_EN adds the resid output carrying the final residual.
module exp_term_decomp #(
  parameter int IW        = 4,
  parameter int MAX_TERMS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW+10:0] x,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           term_valid,
  input  logic           term_ready,
  output logic [3:0]     term_idx,
  output logic [12:0]    term_mul,
  output logic           term_last,
  output logic           done,
  output logic [5:0]     term_cnt,
  output logic           trunc,
`ifdef EXP_TERM_DECOMP_RESID_EN
  output logic [IW+10:0] resid,
`endif
  output logic [1:0]     state_dbg
);

  // Handshakes: a beat transfers on a rising clk edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.

  localparam int RW = IW + 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] r;
  logic [RW-1:0] r_sub;
  logic [RW-1:0] t_sel;
  logic [5:0]    cnt;
  logic [5:0]    cnt_inc;
  logic          found;
  logic [3:0]    sel;
  logic          ready_q;
  logic [3:0]    idx_q;
  logic [12:0]   mul_q;
  logic          last_q;

  function automatic logic [10:0] t_of(input logic [3:0] i);
    case (i)
      4'd0:    t_of = 11'd1420;
      4'd1:    t_of = 11'd830;
      4'd2:    t_of = 11'd457;
      4'd3:    t_of = 11'd241;
      4'd4:    t_of = 11'd124;
      4'd5:    t_of = 11'd63;
      4'd6:    t_of = 11'd32;
      4'd7:    t_of = 11'd16;
      4'd8:    t_of = 11'd8;
      4'd9:    t_of = 11'd4;
      4'd10:   t_of = 11'd2;
      4'd11:   t_of = 11'd1;
      default: t_of = 11'd0;
    endcase
  endfunction

  function automatic logic [12:0] mul_of(input logic [3:0] i);
    if (i == 4'd0) mul_of = 13'd4096;
    else           mul_of = 13'd2048 + (13'd2048 >> i);
  endfunction

  // The table is strictly decreasing, so scanning downward leaves the smallest
  // qualifying index in sel.
  always_comb begin
    found = 1'b0;
    sel   = 4'd0;
    for (int k = 11; k >= 0; k--) begin
      if (RW'(t_of(4'(k))) <= r) begin
        found = 1'b1;
        sel   = 4'(k);
      end
    end
    t_sel   = RW'(t_of(sel));
    r_sub   = r - t_sel;
    cnt_inc = cnt + 6'd1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && ready_q) state_nx = SEARCH;
      SEARCH:  state_nx = found ? EMIT : DONE;
      EMIT:    if (term_ready) state_nx = last_q ? DONE : SEARCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ready_q is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      r       <= '0;
      cnt     <= 6'd0;
      idx_q   <= 4'd0;
      mul_q   <= 13'd0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (in_valid && ready_q) begin
            r   <= x;
            cnt <= 6'd0;
          end
        end
        SEARCH: begin
          if (found) begin
            idx_q  <= sel;
            mul_q  <= mul_of(sel);
            r      <= r_sub;
            cnt    <= cnt_inc;
            last_q <= (r_sub == '0) || (cnt_inc == 6'(MAX_TERMS));
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EXP_TERM_DECOMP_RESID_EN
  logic [RW-1:0] resid_q;

  // r does not change on either path into DONE, so it is already final here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resid_q <= '0;
    else        resid_q <= (state_nx == DONE) ? r : '0;
  end

  assign resid = resid_q;
`endif

  assign in_ready   = ready_q;
  assign term_valid = (state == EMIT);
  assign term_idx   = idx_q;
  assign term_mul   = mul_q;
  assign term_last  = last_q;
  assign done       = (state == DONE);
  assign term_cnt   = cnt;
  assign trunc      = (state == DONE) && (r != '0);
  assign state_dbg  = state;

endmodule

// File: tb/tb_exp_term_decomp.sv
// Directed bench for exp_term_decomp: default instance (IW=4, MAX_TERMS=8) plus a wide instance (IW=8, MAX_TERMS=32).
module tb_exp_term_decomp;

  logic        clk;
  logic        rst_n;
  logic [14:0] x;
  logic        in_valid, in_ready, term_valid, term_ready;
  logic [3:0]  term_idx;
  logic [12:0] term_mul;
  logic        term_last, done, trunc;
  logic [5:0]  term_cnt;
  logic [1:0]  state_dbg;
`ifdef EXP_TERM_DECOMP_RESID_EN
  logic [14:0] resid;
`endif

  logic [18:0] x_b;
  logic        in_valid_b, in_ready_b, term_valid_b, term_ready_b;
  logic [3:0]  term_idx_b;
  logic [12:0] term_mul_b;
  logic        term_last_b, done_b, trunc_b;
  logic [5:0]  term_cnt_b;
  logic [1:0]  state_dbg_b;
`ifdef EXP_TERM_DECOMP_RESID_EN
  logic [18:0] resid_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  exp_term_decomp dut (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .term_valid(term_valid), .term_ready(term_ready), .term_idx(term_idx),
    .term_mul(term_mul), .term_last(term_last), .done(done), .term_cnt(term_cnt),
    .trunc(trunc),
`ifdef EXP_TERM_DECOMP_RESID_EN
    .resid(resid),
`endif
    .state_dbg(state_dbg)
  );

  exp_term_decomp #(.IW(8), .MAX_TERMS(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .term_valid(term_valid_b), .term_ready(term_ready_b), .term_idx(term_idx_b),
    .term_mul(term_mul_b), .term_last(term_last_b), .done(done_b), .term_cnt(term_cnt_b),
    .trunc(trunc_b),
`ifdef EXP_TERM_DECOMP_RESID_EN
    .resid(resid_b),
`endif
    .state_dbg(state_dbg_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_term(input int idx, input int mul);
    exp_q.push_back({4'(idx), 13'(mul)});
  endtask

  task automatic start_op(input string name, input logic [14:0] xv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_idle_ready"}, in_ready, 1);
    x        = xv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 15'h5a5a;
  endtask

  // Collects terms after the accept edge; stall_term < 0 disables the stall.
  task automatic run_op(input string name, input logic [14:0] xv, input int exp_cnt,
                        input int exp_trunc, input int exp_resid,
                        input int stall_term, input int stall_cyc);
    int cyc, hs_cyc, term_n;
    bit got_done;
    logic [16:0] e, held;
    start_op(name, xv);
    cyc = 0; hs_cyc = 0; term_n = 0; got_done = 0;
    while (!got_done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (term_valid) begin
        check({name, "_lat"}, cyc, hs_cyc + 1);
        if (term_n == stall_term) begin
          term_ready = 1'b0;
          held = {term_idx, term_mul};
          for (int s = 0; s < stall_cyc; s++) begin
            @(posedge clk); #1;
            cyc++;
            check({name, "_stall_hold"}, {term_valid, term_idx, term_mul}, {1'b1, held});
          end
          term_ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
          check({name, "_extra_term"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({name, "_idx"}, term_idx, e[16:13]);
          check({name, "_mul"}, term_mul, e[12:0]);
        end
        check({name, "_last"}, term_last, (term_n == exp_cnt - 1));
        term_n++;
        hs_cyc = cyc + 1;
      end else if (done) begin
        got_done = 1;
        check({name, "_done_time"}, cyc, (exp_cnt == 0) ? 1 : hs_cyc);
        check({name, "_term_cnt"}, term_cnt, exp_cnt);
        check({name, "_trunc"}, trunc, exp_trunc);
        check({name, "_n_terms"}, term_n, exp_cnt);
`ifdef EXP_TERM_DECOMP_RESID_EN
        check({name, "_resid"}, resid, exp_resid);
`endif
        @(posedge clk); #1;
        check({name, "_done_pulse"}, done, 0);
      end
    end
    check({name, "_timeout"}, got_done, 1);
    check({name, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
    if (exp_resid < 0) $display("note: negative resid expectation for %s", name);
  endtask

  task automatic push_seq_2048();
    push_term(0, 4096); push_term(2, 2560); push_term(4, 2176); push_term(6, 2080);
    push_term(8, 2056); push_term(9, 2052); push_term(10, 2050); push_term(11, 2049);
  endtask

  task automatic run_reset_mid_op();
    int n, done_seen;
    start_op("rst", 15'd2048);
    n = 0;
    while (!term_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach_emit", term_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_term_valid", term_valid, 0);
    check("rst_term_idx", term_idx, 0);
    check("rst_term_mul", term_mul, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("rst_no_done", done_seen, 0);
    check("rst_ready_after", in_ready, 1);
  endtask

  task automatic run_big();
    int n, cyc, busy_ready;
    bit got_done;
    n = 0; cyc = 0; busy_ready = 0; got_done = 0;
    x_b        = 19'h7ffff;
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    while (!got_done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (term_valid_b) begin
        n++;
        check("big_idx", term_idx_b, 0);
        check("big_mul", term_mul_b, 4096);
        check("big_last", term_last_b, (n == 32));
      end
      if (done_b) begin
        got_done   = 1;
        in_valid_b = 1'b0;
        check("big_term_cnt", term_cnt_b, 32);
        check("big_trunc", trunc_b, 1);
`ifdef EXP_TERM_DECOMP_RESID_EN
        check("big_resid", resid_b, 478847);
`endif
      end else if (in_ready_b) begin
        busy_ready++;
      end
    end
    check("big_timeout", got_done, 1);
    check("big_n_terms", n, 32);
    check("big_busy_ready", busy_ready, 0);
    @(posedge clk); #1;
    check("big_idle_ready", in_ready_b, 1);
    @(posedge clk); #1;
    check("big_no_reaccept", state_dbg_b, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    x            = '0;
    in_valid     = 1'b0;
    term_ready   = 1'b1;
    x_b          = '0;
    in_valid_b   = 1'b0;
    term_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_term_valid", term_valid, 0);
    check("reset_term_idx", term_idx, 0);
    check("reset_term_mul", term_mul, 0);
    check("reset_term_last", term_last, 0);
    check("reset_done", done, 0);
    check("reset_term_cnt", term_cnt, 0);
    check("reset_trunc", trunc, 0);
    check("reset_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);

    push_seq_2048();
    run_op("x2048", 15'd2048, 8, 0, 0, -1, 0);

    push_term(0, 4096);
    run_op("x1420", 15'd1420, 1, 0, 0, -1, 0);

    run_op("x0", 15'd0, 0, 0, 0, -1, 0);

    push_seq_2048();
    run_op("stall", 15'd2048, 8, 0, 0, 1, 5);

    for (int i = 0; i < 8; i++) push_term(0, 4096);
    run_op("xmax", 15'h7fff, 8, 1, 21407, -1, 0);

    push_term(5, 2112); push_term(6, 2080); push_term(9, 2052); push_term(11, 2049);
    run_op("x100", 15'd100, 4, 0, 0, 2, 3);

    run_reset_mid_op();
    push_term(0, 4096);
    run_op("post_rst", 15'd1420, 1, 0, 0, -1, 0);

    run_big();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
